// File: rtl/spi_slave_frontend.sv
// SPI slave serial front end: deserialises MOSI command frames into RAM command words
// and shifts RAM read data back out on MISO.
module spi_slave_frontend #(
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ss_n,
   input  logic                 mosi,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   output logic                 miso
);
   localparam int W  = ADDR_SIZE + 2;
   localparam int CW = $clog2(W + 1);
   localparam int TW = $clog2(ADDR_SIZE);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CHK_CMD   = 3'd1;
   localparam logic [2:0] WRITE     = 3'd2;
   localparam logic [2:0] READ_ADD  = 3'd3;
   localparam logic [2:0] READ_DATA = 3'd4;

   localparam logic [1:0] TX_OFF   = 2'd0;
   localparam logic [1:0] TX_WAIT  = 2'd1;
   localparam logic [1:0] TX_SHIFT = 2'd2;
   localparam logic [1:0] TX_DONE  = 2'd3;

   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [W-2:0]         sr_q, sr_d;
   logic [W-1:0]         rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 miso_q, miso_d;
   logic                 seen_q, seen_d;
   logic [1:0]           txph_q, txph_d;
   logic [ADDR_SIZE-1:0] txsr_q, txsr_d;
   logic [TW-1:0]        txcnt_q, txcnt_d;

   logic word_last;
   logic tx_accept;

   assign word_last = (cnt_q == CW'(W - 1));
   // Read data is also taken on the edge that completes the READ_DATA command word.
   assign tx_accept = tx_valid && (state_q == READ_DATA) &&
                      ((txph_q == TX_WAIT) || ((txph_q == TX_OFF) && word_last));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      miso_d     = 1'b0;
      seen_d     = seen_q;
      txph_d     = txph_q;
      txsr_d     = txsr_q;
      txcnt_d    = txcnt_q;

      case (state_q)
         IDLE: if (!ss_n) state_d = CHK_CMD;
         CHK_CMD: begin
            if (!mosi)       state_d = WRITE;
            else if (seen_q) state_d = READ_DATA;
            else             state_d = READ_ADD;
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (cnt_q < CW'(W)) begin
               sr_d  = {sr_q[W-3:0], mosi};
               cnt_d = cnt_q + CW'(1);
               if (word_last) begin
                  rx_data_d  = {sr_q, mosi};
                  rx_valid_d = 1'b1;
                  if (state_q == READ_ADD)  seen_d = 1'b1;
                  if (state_q == READ_DATA) txph_d = TX_WAIT;
               end
            end
            if (tx_accept) begin
               miso_d  = tx_data[ADDR_SIZE-1];
               txsr_d  = {tx_data[ADDR_SIZE-2:0], 1'b0};
               txcnt_d = TW'(ADDR_SIZE - 1);
               txph_d  = TX_SHIFT;
            end else if (txph_q == TX_SHIFT) begin
               miso_d  = txsr_q[ADDR_SIZE-1];
               txsr_d  = {txsr_q[ADDR_SIZE-2:0], 1'b0};
               txcnt_d = txcnt_q - TW'(1);
               if (txcnt_q == TW'(1)) begin
                  txph_d = TX_DONE;
                  seen_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Deselect wins over everything in flight, including a word completing this edge.
      if (ss_n && (state_q != IDLE)) begin
         state_d    = IDLE;
         cnt_d      = '0;
         sr_d       = '0;
         rx_data_d  = rx_data_q;
         rx_valid_d = 1'b0;
         miso_d     = 1'b0;
         seen_d     = seen_q;
         txph_d     = TX_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
         seen_q     <= 1'b0;
         txph_q     <= TX_OFF;
         txsr_q     <= '0;
         txcnt_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         seen_q     <= seen_d;
         txph_q     <= txph_d;
         txsr_q     <= txsr_d;
         txcnt_q    <= txcnt_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign miso     = miso_q;
endmodule
